// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: per-channel lock supervisor for the synthesizer bank.
// Synchronises and debounces each lock-detect pin, tracks acquisition after
// every reprogram, and keeps sticky timeout / unlock flags plus a global alarm.
// Optional feature macro: PLL_LOCK_UNLOCK_CNT_EN adds per-channel saturating
// 8-bit unlock event counters on output unlock_cnt.
module pll_lock_monitor #(
  parameter int unsigned CHANNELS            = 6,
  parameter bit          LOCK_ACTIVE_LEVEL   = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES     = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 33333,
  parameter int unsigned TMO_W               = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   lock_raw,
  input  logic [CHANNELS-1:0]   busy,
  input  logic [CHANNELS-1:0]   clr_flags,
  output logic [CHANNELS-1:0]   lock_db,
  output logic [CHANNELS-1:0]   lock_ok,
  output logic [CHANNELS-1:0]   tmo_flag,
  output logic [CHANNELS-1:0]   unlock_flag,
  output logic                  alarm
`ifdef PLL_LOCK_UNLOCK_CNT_EN
  ,
  output logic [CHANNELS*8-1:0] unlock_cnt
`endif
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PROG   = 3'd1;
  localparam logic [2:0] ST_ACQ    = 3'd2;
  localparam logic [2:0] ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_LOST   = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  logic [CHANNELS-1:0] lock_norm_c;
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;
  logic [CHANNELS-1:0] db_q, db_d;
  logic [CHANNELS-1:0] ok_q, ok_d;
  logic [CHANNELS-1:0] tmo_q, tmo_d;
  logic [CHANNELS-1:0] unl_q, unl_d;
  logic                alarm_q, alarm_d;
  logic [CHANNELS-1:0] tmo_set_c;
  logic [CHANNELS-1:0] unl_set_c;

  logic [DB_W-1:0]     dbc_q [CHANNELS];
  logic [DB_W-1:0]     dbc_d [CHANNELS];
  logic [TMO_W-1:0]    tmc_q [CHANNELS];
  logic [TMO_W-1:0]    tmc_d [CHANNELS];
  logic [2:0]          st_q  [CHANNELS];
  logic [2:0]          st_d  [CHANNELS];
`ifdef PLL_LOCK_UNLOCK_CNT_EN
  logic [7:0]          ucnt_q [CHANNELS];
  logic [7:0]          ucnt_d [CHANNELS];
`endif

  // Normalise pins to active-high before they enter the synchroniser
  assign lock_norm_c = lock_raw ^ {CHANNELS{~LOCK_ACTIVE_LEVEL}};

  // Next-state logic: synchroniser, debounce, supervisor FSM, sticky flags
  always_comb begin
    sync1_d   = lock_norm_c;
    sync2_d   = sync1_q;
    db_d      = db_q;
    tmo_d     = tmo_q;
    unl_d     = unl_q;
    ok_d      = '0;
    tmo_set_c = '0;
    unl_set_c = '0;
    alarm_d   = |(tmo_q | unl_q);
    for (int i = 0; i < CHANNELS; i++) begin
      dbc_d[i] = dbc_q[i];
      tmc_d[i] = tmc_q[i];
      st_d[i]  = st_q[i];
`ifdef PLL_LOCK_UNLOCK_CNT_EN
      ucnt_d[i] = ucnt_q[i];
`endif

      // Debounce: count consecutive samples that disagree with lock_db
      if (sync2_q[i] == db_q[i]) begin
        dbc_d[i] = '0;
      end else if (dbc_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]  = sync2_q[i];
        dbc_d[i] = '0;
      end else begin
        dbc_d[i] = dbc_q[i] + DB_W'(1);
      end

      // Supervisor FSM; busy overrides everything
      if (busy[i]) begin
        st_d[i] = ST_PROG;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            if (db_q[i]) st_d[i] = ST_LOCKED;
          end
          ST_PROG: begin
            st_d[i]  = ST_ACQ;
            tmc_d[i] = '0;
          end
          ST_ACQ: begin
            if (db_q[i]) begin
              st_d[i] = ST_LOCKED;
            end else if (tmc_q[i] == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
              st_d[i]      = ST_FAIL;
              tmo_set_c[i] = 1'b1;
            end else begin
              tmc_d[i] = tmc_q[i] + TMO_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!db_q[i]) begin
              st_d[i]      = ST_LOST;
              unl_set_c[i] = 1'b1;
            end
          end
          ST_LOST, ST_FAIL: begin
            if (db_q[i]) st_d[i] = ST_LOCKED;
          end
          default: st_d[i] = ST_IDLE;
        endcase
      end

      // Sticky flags: a set event beats a simultaneous clear
      tmo_d[i] = tmo_set_c[i] | (tmo_q[i] & ~clr_flags[i]);
      unl_d[i] = unl_set_c[i] | (unl_q[i] & ~clr_flags[i]);
      ok_d[i]  = (st_d[i] == ST_LOCKED);

`ifdef PLL_LOCK_UNLOCK_CNT_EN
      // Saturating unlock counter; increment with clear lands on 1
      if (unl_set_c[i]) begin
        if (clr_flags[i]) begin
          ucnt_d[i] = 8'd1;
        end else if (ucnt_q[i] != 8'hFF) begin
          ucnt_d[i] = ucnt_q[i] + 8'd1;
        end
      end else if (clr_flags[i]) begin
        ucnt_d[i] = '0;
      end
`endif
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      ok_q    <= '0;
      tmo_q   <= '0;
      unl_q   <= '0;
      alarm_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        dbc_q[i] <= '0;
        tmc_q[i] <= '0;
        st_q[i]  <= ST_IDLE;
`ifdef PLL_LOCK_UNLOCK_CNT_EN
        ucnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      ok_q    <= ok_d;
      tmo_q   <= tmo_d;
      unl_q   <= unl_d;
      alarm_q <= alarm_d;
      for (int i = 0; i < CHANNELS; i++) begin
        dbc_q[i] <= dbc_d[i];
        tmc_q[i] <= tmc_d[i];
        st_q[i]  <= st_d[i];
`ifdef PLL_LOCK_UNLOCK_CNT_EN
        ucnt_q[i] <= ucnt_d[i];
`endif
      end
    end
  end

  assign lock_db     = db_q;
  assign lock_ok     = ok_q;
  assign tmo_flag    = tmo_q;
  assign unlock_flag = unl_q;
  assign alarm       = alarm_q;

`ifdef PLL_LOCK_UNLOCK_CNT_EN
  // Flatten per-channel counters onto the output bus
  always_comb begin
    unlock_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      unlock_cnt[i*8 +: 8] = ucnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Testbench for pll_lock_monitor: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model through a scoreboard queue.
module tb_pll_lock_monitor;

  localparam int CH  = 6;
  localparam int DB  = 4;
  localparam int TMO = 100;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   lock_raw;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   clr_flags;
  logic [CH-1:0]   lock_db;
  logic [CH-1:0]   lock_ok;
  logic [CH-1:0]   tmo_flag;
  logic [CH-1:0]   unlock_flag;
  logic            alarm;
`ifdef PLL_LOCK_UNLOCK_CNT_EN
  logic [CH*8-1:0] unlock_cnt;
`endif

  pll_lock_monitor #(
    .CHANNELS           (CH),
    .LOCK_ACTIVE_LEVEL  (1'b0),
    .DEBOUNCE_CYCLES    (DB),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .TMO_W              (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_raw   (lock_raw),
    .busy       (busy),
    .clr_flags  (clr_flags),
    .lock_db    (lock_db),
    .lock_ok    (lock_ok),
    .tmo_flag   (tmo_flag),
    .unlock_flag(unlock_flag),
    .alarm      (alarm)
`ifdef PLL_LOCK_UNLOCK_CNT_EN
    ,
    .unlock_cnt (unlock_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_PROG, M_ACQ, M_LOCKED, M_LOST, M_FAIL} mst_t;

  typedef struct packed {
    logic [CH-1:0]   db;
    logic [CH-1:0]   ok;
    logic [CH-1:0]   tmo;
    logic [CH-1:0]   unl;
    logic            alarm;
    logic [CH*8-1:0] ucnt;
  } exp_t;

  exp_t          exp_q[$];
  mst_t          m_st  [CH];
  int            m_age [CH];
  int            m_ucnt[CH];
  logic [DB-1:0] m_win [CH];
  logic [CH-1:0] m_s1, m_s2, m_db, m_tmo, m_unl, m_ok;
  logic          m_alarm;

  // Model advances on each edge from the inputs the DUT samples there
  always @(posedge clk) begin
    exp_t          e;
    logic [CH-1:0] old_db;
    logic          s;
    bit            set_t, set_u;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_tmo = '0; m_unl = '0; m_ok = '0;
      m_alarm = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_st[c] = M_IDLE; m_age[c] = 0; m_ucnt[c] = 0; m_win[c] = '0;
      end
    end else begin
      old_db  = m_db;
      m_alarm = |(m_tmo | m_unl);
      // Debounced value changes once the last DB synced samples all disagree
      for (int c = 0; c < CH; c++) begin
        s = m_s2[c];
        m_win[c] = {m_win[c][DB-2:0], s};
        if (m_win[c] == {DB{~m_db[c]}}) m_db[c] = s;
      end
      m_s2 = m_s1;
      m_s1 = ~lock_raw;
      for (int c = 0; c < CH; c++) begin
        set_t = 0;
        set_u = 0;
        if (busy[c]) begin
          m_st[c] = M_PROG;
        end else begin
          case (m_st[c])
            M_IDLE:   if (old_db[c]) m_st[c] = M_LOCKED;
            M_PROG:   begin m_st[c] = M_ACQ; m_age[c] = 0; end
            M_ACQ: begin
              if (old_db[c]) m_st[c] = M_LOCKED;
              else begin
                m_age[c]++;
                if (m_age[c] == TMO) begin m_st[c] = M_FAIL; set_t = 1; end
              end
            end
            M_LOCKED: if (!old_db[c]) begin m_st[c] = M_LOST; set_u = 1; end
            default:  if (old_db[c]) m_st[c] = M_LOCKED;
          endcase
        end
        if (set_t) m_tmo[c] = 1'b1; else if (clr_flags[c]) m_tmo[c] = 1'b0;
        if (set_u) m_unl[c] = 1'b1; else if (clr_flags[c]) m_unl[c] = 1'b0;
        if (set_u) m_ucnt[c] = clr_flags[c] ? 1 : ((m_ucnt[c] >= 255) ? 255 : m_ucnt[c] + 1);
        else if (clr_flags[c]) m_ucnt[c] = 0;
        m_ok[c] = (m_st[c] == M_LOCKED);
      end
    end
    e.db    = m_db;
    e.ok    = m_ok;
    e.tmo   = m_tmo;
    e.unl   = m_unl;
    e.alarm = m_alarm;
    for (int c = 0; c < CH; c++) e.ucnt[c*8 +: 8] = 8'(m_ucnt[c]);
    exp_q.push_back(e);
  end

  // Monitor: pops one expectation per presented output cycle and compares
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lock_db", 64'(lock_db), 64'(e.db));
      chk("lock_ok", 64'(lock_ok), 64'(e.ok));
      chk("tmo_flag", 64'(tmo_flag), 64'(e.tmo));
      chk("unlock_flag", 64'(unlock_flag), 64'(e.unl));
      chk("alarm", 64'(alarm), 64'(e.alarm));
`ifdef PLL_LOCK_UNLOCK_CNT_EN
      chk("unlock_cnt", 64'(unlock_cnt), 64'(e.ucnt));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; lock_raw = '1; busy = '0; clr_flags = '0;
    tick(2);

    // Lock from IDLE on channel 0
    rst = 1'b1;
    lock_raw[0] = 1'b0;
    tick(5);
    chk("idle_db_early", 64'(lock_db[0]), 64'd0);
    tick(1);
    chk("idle_db_6th", 64'(lock_db[0]), 64'd1);
    chk("idle_ok_6th", 64'(lock_ok[0]), 64'd0);
    tick(1);
    chk("idle_ok_7th", 64'(lock_ok[0]), 64'd1);
    chk("idle_tmo", 64'(tmo_flag), 64'd0);
    chk("idle_alarm", 64'(alarm), 64'd0);

    // Glitch rejection on channel 2
    lock_raw[2] = 1'b0;
    tick(10);
    lock_raw[2] = 1'b1;
    tick(3);
    lock_raw[2] = 1'b0;
    tick(8);
    chk("glitch_db", 64'(lock_db[2]), 64'd1);
    chk("glitch_ok", 64'(lock_ok[2]), 64'd1);
    chk("glitch_unl", 64'(unlock_flag[2]), 64'd0);

    // Acquisition timeout on channel 1, then late lock
    busy[1] = 1'b1;
    tick(10);
    chk("busy_ok", 64'(lock_ok[1]), 64'd0);
    busy[1] = 1'b0;
    tick(100);
    chk("tmo_before", 64'(tmo_flag[1]), 64'd0);
    tick(1);
    chk("tmo_set", 64'(tmo_flag[1]), 64'd1);
    chk("tmo_alarm_lag", 64'(alarm), 64'd0);
    tick(1);
    chk("tmo_alarm", 64'(alarm), 64'd1);
    lock_raw[1] = 1'b0;
    tick(8);
    chk("late_lock_ok", 64'(lock_ok[1]), 64'd1);
    chk("late_lock_tmo", 64'(tmo_flag[1]), 64'd1);

    // Loss of lock on channel 4
    lock_raw[4] = 1'b0;
    tick(10);
    lock_raw[4] = 1'b1;
    tick(10);
    chk("loss_unl", 64'(unlock_flag[4]), 64'd1);
    chk("loss_ok", 64'(lock_ok[4]), 64'd0);
    lock_raw[4] = 1'b0;
    tick(10);
    chk("relock_ok", 64'(lock_ok[4]), 64'd1);
    chk("relock_unl", 64'(unlock_flag[4]), 64'd1);
    clr_flags[4] = 1'b1;
    tick(1);
    clr_flags[4] = 1'b0;
    chk("clr_unl", 64'(unlock_flag[4]), 64'd0);

    // Set/clear collision on channel 3
    busy[3] = 1'b1;
    tick(2);
    busy[3] = 1'b0;
    tick(100);
    clr_flags[3] = 1'b1;
    tick(1);
    clr_flags[3] = 1'b0;
    chk("collide_tmo", 64'(tmo_flag[3]), 64'd1);
    clr_flags[3] = 1'b1;
    tick(1);
    clr_flags[3] = 1'b0;
    chk("clear_tmo", 64'(tmo_flag[3]), 64'd0);

    // Reset in the middle of acquisition on channel 5
    busy[5] = 1'b1;
    tick(2);
    busy[5] = 1'b0;
    tick(51);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("rst_db", 64'(lock_db), 64'd0);
    chk("rst_ok", 64'(lock_ok), 64'd0);
    chk("rst_tmo", 64'(tmo_flag), 64'd0);
    chk("rst_unl", 64'(unlock_flag), 64'd0);
    chk("rst_alarm", 64'(alarm), 64'd0);
    tick(150);
    chk("rst_no_tmo", 64'(tmo_flag), 64'd0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) lock_raw[c] = ~lock_raw[c];
        busy[c]      = ($urandom_range(0, 149) == 0);
        clr_flags[c] = ($urandom_range(0, 59) == 0);
      end
      rst = ($urandom_range(0, 799) != 0);
      tick(1);
    end
    rst = 1'b1; busy = '0; clr_flags = '0;

`ifdef PLL_LOCK_UNLOCK_CNT_EN
    // Saturation of the unlock counter on channel 0
    lock_raw[0] = 1'b0;
    clr_flags[0] = 1'b1;
    tick(10);
    clr_flags[0] = 1'b0;
    for (int k = 0; k < 300; k++) begin
      lock_raw[0] = 1'b1;
      tick(8);
      lock_raw[0] = 1'b0;
      tick(8);
    end
    chk("ucnt_sat", 64'(unlock_cnt[7:0]), 64'd255);
`endif

    tick(3);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Per-channel lock supervisor for the six ADF4159 synthesizers. Sits downstream of the synthesizer programming engines: consumes each channel's raw lock-detect pin and `busy` flag. After every reprogram it tracks acquisition, lock and loss of lock, and produces debounced lock status plus sticky timeout/unlock flags for the master SPI reply path.

## Interface
Parameters:
- `CHANNELS`, 6, number of synthesizer channels
- `LOCK_ACTIVE_LEVEL`, 0, level of `lock_raw` meaning "locked" (board pins are active-low)
- `DEBOUNCE_CYCLES`, 64, consecutive stable samples required to change the debounced lock, ≥2
- `LOCK_TIMEOUT_CYCLES`, 33333, acquisition window after programming ends (1 ms at 30 ns)
- `TMO_W`, 16, timeout counter width; must hold `LOCK_TIMEOUT_CYCLES-1`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-low
- `lock_raw`  in  CHANNELS  asynchronous lock-detect pins
- `busy`  in  CHANNELS  per-channel programming-in-progress from the synthesizer writers
- `clr_flags`  in  CHANNELS  one-cycle pulse clears that channel's sticky flags
- `lock_db`  out  CHANNELS  debounced lock, active-high
- `lock_ok`  out  CHANNELS  channel in LOCKED state
- `tmo_flag`  out  CHANNELS  sticky: acquisition timed out
- `unlock_flag`  out  CHANNELS  sticky: lock lost after being acquired
- `alarm`  out  1  registered OR of all `tmo_flag | unlock_flag`

## Operation
- Input path per channel:
  - 2-flop synchronizer on `lock_raw`, normalised to active-high with `LOCK_ACTIVE_LEVEL`.
  - Debounce counter counts cycles where the synced value ≠ `lock_db`; it clears when they are equal.
  - On reaching `DEBOUNCE_CYCLES` consecutive differing samples, `lock_db` takes the synced value and the counter clears.
- Per-channel FSM (`busy[i]`=1 forces PROG from any state; highest priority):
  - IDLE: `lock_db` → LOCKED. Never times out.
  - PROG: `busy`=0 → ACQ, timeout counter ← 0.
  - ACQ: `lock_db` → LOCKED; else if counter == `LOCK_TIMEOUT_CYCLES-1` → FAIL and set `tmo_flag`; else counter+1.
  - LOCKED: `!lock_db` → LOST and set `unlock_flag`.
  - LOST: `lock_db` → LOCKED. Flag stays set.
  - FAIL: `lock_db` → LOCKED (late lock). `tmo_flag` stays set.
- `lock_ok[i]` = (state == LOCKED), registered.
- Sticky flags: a set event and `clr_flags[i]` in the same cycle → set wins. `clr_flags` on a clear flag has no effect.
- `busy` pulses during ACQ restart the acquisition; no flag is raised.
- Channels are fully independent; no shared counters.

## Timing
- Reset (`rst`=0 at a clock edge): all FSMs IDLE; synchronizers, `lock_db`, `lock_ok`, `tmo_flag`, `unlock_flag` and `alarm` all 0; counters 0.
- Reset mid-acquisition discards all state. No flag survives.
- Lock latency: `lock_raw` held at the new level → `lock_db` changes `DEBOUNCE_CYCLES+2` edges after the first sampling edge. `lock_ok` follows 1 edge later.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles never change `lock_db`.
- Timeout: with `lock_db`=0 throughout, `tmo_flag` rises `LOCK_TIMEOUT_CYCLES+1` edges after the edge that samples `busy` falling.
- `busy` rising → state PROG and `lock_ok`=0 on the next edge.
- `alarm` lags the flags by 1 cycle.

## Configuration
- `PLL_LOCK_UNLOCK_CNT_EN`:
  - Defined: adds output `unlock_cnt` (CHANNELS×8). Per-channel 8-bit counter increments on each LOCKED→LOST transition, saturates at 255, is cleared by `clr_flags[i]`, and resets to 0. If increment and clear coincide, the result is 1.
  - Undefined: port and counters absent; all other behaviour identical.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=100, `LOCK_ACTIVE_LEVEL`=0.
- Reset/IDLE lock: release reset, drive `lock_raw[0]`=0 steadily → `lock_db[0]`=1 at 6th edge, `lock_ok[0]`=1 at 7th; `tmo_flag`=0, `alarm`=0.
- Glitch rejection: channel locked, pulse `lock_raw[2]`=1 for 3 cycles → `lock_db[2]`, `lock_ok[2]` stay 1; `unlock_flag[2]`=0.
- Timeout: `busy[1]`=1 for 10 cycles then 0, `lock_raw[1]`=1 → `tmo_flag[1]`=1 101 edges after `busy` falls, `alarm`=1 one cycle later; then lock asserts → `lock_ok[1]`=1, `tmo_flag[1]` stays 1.
- Loss of lock: LOCKED channel 4, hold `lock_raw[4]`=1 for 10 cycles → `unlock_flag[4]`=1, `lock_ok[4]`=0. Reassert lock → `lock_ok[4]`=1, flag held. `clr_flags[4]` pulse → flag 0.
- Set/clear collision: assert `clr_flags[3]` on the cycle `tmo_flag[3]` would set → `tmo_flag[3]`=1.
- Reset mid-ACQ: `rst`=0 for 1 cycle at ACQ count 50 → all outputs 0, FSM IDLE, no timeout afterwards without new `busy`. With `PLL_LOCK_UNLOCK_CNT_EN`, 300 unlock events give `unlock_cnt[7:0]`=255.
